// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_gen_pipe                                                    |
// | Purpose  : Pipelined RV immediate generator with valid/ready handshake and |
// |            a 2-entry skid buffer (main + skid). The immediate is built     |
// |            combinationally from instr[31:7] and stored on acceptance; the  |
// |            main entry drives the outputs one cycle later.                  |
// | Ports    : clk_i, rst_ni      - clock (rising edge), async active-low rst  |
// |            flush_i            - synchronous kill of all buffered entries   |
// |            valid_i / ready_o  - upstream handshake (ready_o is a flop)     |
// |            sel_imm_i, instr_i - format select, instruction bits [31:7]     |
// |            valid_o / ready_i  - downstream handshake                       |
// |            imm_o, fmt_err_o   - immediate and illegal-select flag          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      sel_imm_i,
  input  logic [24:0]     instr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic            fmt_err_o
);

  localparam logic [2:0] C_SEL_I  = 3'd0;
  localparam logic [2:0] C_SEL_S  = 3'd1;
  localparam logic [2:0] C_SEL_B  = 3'd2;
  localparam logic [2:0] C_SEL_U  = 3'd3;
  localparam logic [2:0] C_SEL_J  = 3'd4;
  localparam logic [2:0] C_SEL_Z  = 3'd5;
  localparam logic [2:0] C_SEL_SH = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Index the instruction by its architectural bit numbers.
  logic [31:7] ins;
  assign ins = instr_i;

  // Formats whose layout depends on XLEN.
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] sh_imm;

  if (XLEN == 64) begin : g_x64
    assign u_imm  = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
    assign sh_imm = {{(XLEN-6){1'b0}}, ins[25:20]};
  end else begin : g_x32
    assign u_imm  = {ins[31:12], 12'b0};
    assign sh_imm = {{(XLEN-5){1'b0}}, ins[24:20]};
  end

  // Immediate decode of the incoming beat.
  logic [XLEN-1:0] new_imm;
  logic            new_err;

  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    case (sel_imm_i)
      C_SEL_I:  new_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
      C_SEL_S:  new_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      C_SEL_B:  new_imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      C_SEL_U:  new_imm = u_imm;
      C_SEL_J:  new_imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      C_SEL_Z:  new_imm = {{(XLEN-5){1'b0}}, ins[19:15]};
      C_SEL_SH: new_imm = sh_imm;
      default:  new_err = 1'b1;
    endcase
  end

  // Buffer state.
  state_e          state_q, state_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic            main_err_q, main_err_d;
  logic            main_vld_q, main_vld_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            skid_err_q, skid_err_d;
  logic            skid_vld_q, skid_vld_d;
  logic            ready_q, ready_d;

  logic push;
  logic pop;

  assign push = valid_i & ready_q;
  assign pop  = main_vld_q & ready_i;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_err_d = main_err_q;
    skid_imm_d = skid_imm_q;
    skid_err_d = skid_err_q;

    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_imm_d = new_imm;
            main_err_d = new_err;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_imm_d = new_imm;
            main_err_d = new_err;
          end else if (push) begin
            skid_imm_d = new_imm;
            skid_err_d = new_err;
            state_d    = ST_FULL;
          end else if (pop) begin
            // imm/err intentionally keep their last value when emptied.
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // ready_q is low here, so no push can arrive.
          if (pop) begin
            main_imm_d = skid_imm_q;
            main_err_d = skid_err_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Entry valid bits follow occupancy; ready is registered from the
    // next skid valid so nothing downstream reaches ready_o combinationally.
    main_vld_d = (state_d != ST_EMPTY);
    skid_vld_d = (state_d == ST_FULL);
    ready_d    = ~skid_vld_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      main_imm_q <= '0;
      main_err_q <= 1'b0;
      main_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_err_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_imm_q <= main_imm_d;
      main_err_q <= main_err_d;
      main_vld_q <= main_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_err_q <= skid_err_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = main_vld_q;
  assign imm_o     = main_imm_q;
  assign fmt_err_o = main_err_q;

endmodule
`default_nettype wire
